// File: rtl/pc_sequencer_if.sv
// Fetch handshake bundle between the PC sequencer and instruction memory.
//   fetch_req  : sequencer -> memory, fetch request
//   fetch_addr : sequencer -> memory, address of the requested instruction
//   fetch_ack  : memory -> sequencer, current fetch accepted
interface pc_sequencer_if;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic       fetch_ack;

  modport master (
    output fetch_req,
    output fetch_addr,
    input  fetch_ack
  );

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    output fetch_ack
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, runs the req/ack fetch handshake and
// picks the next fetch address (step, jump, call, return, interrupt vector).
//
// Optional build macro: PC_SEQ_STACK_EN builds the return-address stack. Without
// it, call acts as jump, irq vectors without pushing, ret steps the PC, and the
// stack flags are tied low.
//
// Ports:
//   clk, reset_n     : clock (rising edge), asynchronous active-low reset
//   fetch_bus        : master side of the fetch handshake (req/addr out, ack in)
//   pc               : current PC register
//   stall            : freeze fetching
//   jump/call/ret    : redirect requests from decode, jump_addr is the target
//   irq, irq_ack     : level interrupt request, one-cycle taken pulse
//   stack_ovf/unf    : sticky push-on-full / pop-on-empty flags
module pc_sequencer #(
  parameter logic [7:0]  RESET_VEC   = 8'h00,
  parameter logic [7:0]  STEP        = 8'd4,
  parameter logic [7:0]  IRQ_VEC     = 8'hF0,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pc_sequencer_if.master        fetch_bus,
  output logic [7:0]            pc,
  input  logic                  stall,
  input  logic                  jump,
  input  logic                  call,
  input  logic                  ret,
  input  logic [7:0]            jump_addr,
  input  logic                  irq,
  output logic                  irq_ack,
  output logic                  stack_ovf,
  output logic                  stack_unf
);

  if (STACK_DEPTH < 1 || STACK_DEPTH > 8) begin : gen_bad_depth
    $error("pc_sequencer: STACK_DEPTH must be in 1..8");
  end

  typedef enum logic [1:0] {StBoot, StFetch, StStall} state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d, pc_inc;
  logic       in_svc_q, in_svc_d;
  logic       irq_ack_q, irq_ack_d;
  logic       accept;
  logic       push_req, pop_req;
  logic       pop_valid;
  logic [7:0] pop_data;

  assign pc_inc               = pc_q + STEP;  // 8-bit wrap is intended
  assign fetch_bus.fetch_req  = (state_q == StFetch);
  assign fetch_bus.fetch_addr = pc_q;
  assign pc                   = pc_q;
  assign irq_ack              = irq_ack_q;
  // An ack outside StFetch has no request to pair with and is dropped.
  assign accept               = fetch_bus.fetch_req & fetch_bus.fetch_ack;

  // A stall seen together with an ack still lets that fetch complete.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StFetch;
      StFetch: if (stall) state_d = StStall;
      StStall: if (!stall) state_d = StFetch;
      default: state_d = StBoot;
    endcase
  end

  // Redirects are only looked at on accepted fetches.
  always_comb begin
    pc_d      = pc_q;
    in_svc_d  = in_svc_q;
    irq_ack_d = 1'b0;
    push_req  = 1'b0;
    pop_req   = 1'b0;
    if (accept) begin
      if (irq && !in_svc_q) begin
        pc_d      = IRQ_VEC;
        push_req  = 1'b1;
        in_svc_d  = 1'b1;
        irq_ack_d = 1'b1;
      end else if (jump) begin
        pc_d = jump_addr;
      end else if (call) begin
        pc_d     = jump_addr;
        push_req = 1'b1;
      end else if (ret) begin
        pop_req  = 1'b1;
        in_svc_d = 1'b0;
        pc_d     = pop_valid ? pop_data : pc_inc;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StBoot;
      pc_q      <= RESET_VEC;
      in_svc_q  <= 1'b0;
      irq_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      in_svc_q  <= in_svc_d;
      irq_ack_q <= irq_ack_d;
    end
  end

`ifdef PC_SEQ_STACK_EN
  localparam int unsigned SpW  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [7:0]     stack_q [STACK_DEPTH];
  logic [SpW-1:0] sp_q, sp_d, sp_m1;
  logic           ovf_q, ovf_d, unf_q, unf_d;
  logic           stack_full, stack_empty, do_write;
  logic           unused_sp_m1;

  assign stack_full   = (sp_q == SpW'(STACK_DEPTH));
  assign stack_empty  = (sp_q == '0);
  assign sp_m1        = sp_q - SpW'(1);
  assign unused_sp_m1 = ^sp_m1;
  assign pop_valid    = !stack_empty;
  assign pop_data     = stack_q[sp_m1[IdxW-1:0]];
  assign stack_ovf    = ovf_q;
  assign stack_unf    = unf_q;

  // Push and pop never coincide: they come from exclusive priority branches.
  always_comb begin
    sp_d     = sp_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    do_write = 1'b0;
    if (push_req) begin
      if (stack_full) begin
        ovf_d = 1'b1;
      end else begin
        do_write = 1'b1;
        sp_d     = sp_q + SpW'(1);
      end
    end
    if (pop_req) begin
      if (stack_empty) unf_d = 1'b1;
      else             sp_d  = sp_m1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entries are only read below the stack pointer, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (do_write) stack_q[sp_q[IdxW-1:0]] <= pc_inc;
  end
`else
  logic unused_stack;

  assign pop_valid    = 1'b0;
  assign pop_data     = pc_inc;
  assign stack_ovf    = 1'b0;
  assign stack_unf    = 1'b0;
  assign unused_stack = push_req | pop_req;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table of per-cycle stimulus with
// hand-computed expected outputs, routed through an expected-result queue.
module tb_pc_sequencer;

`ifdef PC_SEQ_STACK_EN
  localparam logic S = 1'b1;
`else
  localparam logic S = 1'b0;
`endif

  // Control word {stall, ack, jump, call, ret, irq}
  localparam logic [5:0] C0  = 6'b000000;
  localparam logic [5:0] CA  = 6'b010000;
  localparam logic [5:0] CJ  = 6'b011000;
  localparam logic [5:0] CC  = 6'b010100;
  localparam logic [5:0] CR  = 6'b010010;
  localparam logic [5:0] CI  = 6'b010001;
  localparam logic [5:0] CS  = 6'b100000;
  localparam logic [5:0] CSA = 6'b110000;
  localparam logic [5:0] CJC = 6'b011100;
  localparam logic [5:0] CIJ = 6'b011101;
  // Flags {irq_ack, stack_ovf, stack_unf}
  localparam logic [2:0] F0  = 3'b000;
  localparam logic [2:0] FI  = 3'b100;
  localparam logic [2:0] FO  = {1'b0, S, 1'b0};
  localparam logic [2:0] FOU = {1'b0, S, S};

  typedef struct packed {
    logic       req;
    logic [7:0] addr;
    logic [2:0] flags;
  } obs_t;

  typedef struct {
    string      name;
    logic [5:0] ctl;
    logic [7:0] jaddr;
    obs_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       stall, jump, call, ret, irq;
  logic [7:0] jump_addr;
  logic [7:0] pc;
  logic       irq_ack, stack_ovf, stack_unf;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  obs_t exp_q[$];

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .fetch_bus (bus),
    .pc        (pc),
    .stall     (stall),
    .jump      (jump),
    .call      (call),
    .ret       (ret),
    .jump_addr (jump_addr),
    .irq       (irq),
    .irq_ack   (irq_ack),
    .stack_ovf (stack_ovf),
    .stack_unf (stack_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100us");
    $fatal(1);
  end

  function automatic vec_t v(string nm, logic [5:0] ctl, logic [7:0] ja, logic r,
                             logic [7:0] a, logic [2:0] f);
    vec_t t;
    t.name  = nm;
    t.ctl   = ctl;
    t.jaddr = ja;
    t.exp   = '{req: r, addr: a, flags: f};
    return t;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.req   = bus.fetch_req;
    o.addr  = bus.fetch_addr;
    o.flags = {irq_ack, stack_ovf, stack_unf};
    return o;
  endfunction

  task automatic check(input string nm, input obs_t got, input obs_t want);
    checks++;
    if (got !== want || pc !== want.addr) begin
      errors++;
      $display("FAIL %s: got req=%b addr=%h pc=%h flags=%b, want req=%b addr=%h flags=%b",
               nm, got.req, got.addr, pc, got.flags, want.req, want.addr, want.flags);
    end
  endtask

  task automatic drive(input logic [5:0] ctl, input logic [7:0] ja);
    {stall, bus.fetch_ack, jump, call, ret, irq} = ctl;
    jump_addr = ja;
  endtask

  task automatic run_vec(input vec_t t);
    obs_t want;
    drive(t.ctl, t.jaddr);
    exp_q.push_back(t.exp);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check(t.name, sample(), want);
  endtask

  initial begin
    drive(C0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("reset", sample(), '{req: 1'b0, addr: 8'h00, flags: F0});
    reset_n = 1'b1;
    check("boot", sample(), '{req: 1'b0, addr: 8'h00, flags: F0});
    run_vec(v("first_req", C0, 8'h00, 1'b1, 8'h00, F0));

    // Ack tied high: one fetch per cycle, wraps FC -> 00.
    for (int i = 1; i <= 64; i++) begin
      run_vec(v($sformatf("seq_%0d", i), CA, 8'h00, 1'b1, 8'(i * 4), F0));
    end

    tbl.push_back(v("step_04",    CA,  8'h00, 1'b1, 8'h04, F0));
    tbl.push_back(v("step_08",    CA,  8'h00, 1'b1, 8'h08, F0));
    tbl.push_back(v("noack_1",    C0,  8'h00, 1'b1, 8'h08, F0));
    tbl.push_back(v("noack_2",    C0,  8'h00, 1'b1, 8'h08, F0));
    tbl.push_back(v("noack_3",    C0,  8'h00, 1'b1, 8'h08, F0));
    tbl.push_back(v("ack_0c",     CA,  8'h00, 1'b1, 8'h0C, F0));
    tbl.push_back(v("ack_10",     CA,  8'h00, 1'b1, 8'h10, F0));
    tbl.push_back(v("stall_1",    CS,  8'h00, 1'b0, 8'h10, F0));
    tbl.push_back(v("stall_ign",  CSA, 8'h00, 1'b0, 8'h10, F0));
    tbl.push_back(v("unstall",    CA,  8'h00, 1'b1, 8'h10, F0));
    tbl.push_back(v("ack_14",     CA,  8'h00, 1'b1, 8'h14, F0));
    tbl.push_back(v("ack_18",     CA,  8'h00, 1'b1, 8'h18, F0));
    tbl.push_back(v("ack_1c",     CA,  8'h00, 1'b1, 8'h1C, F0));
    tbl.push_back(v("ack_20",     CA,  8'h00, 1'b1, 8'h20, F0));
    tbl.push_back(v("call_80",    CC,  8'h80, 1'b1, 8'h80, F0));
    tbl.push_back(v("ret_call",   CR,  8'h00, 1'b1, S ? 8'h24 : 8'h84, F0));
    tbl.push_back(v("jump_30",    CJ,  8'h30, 1'b1, 8'h30, F0));
    tbl.push_back(v("irq_prio",   CIJ, 8'h55, 1'b1, 8'hF0, FI));
    tbl.push_back(v("iack_pulse", C0,  8'h00, 1'b1, 8'hF0, F0));
    tbl.push_back(v("irq_insvc",  CI,  8'h00, 1'b1, 8'hF4, F0));
    tbl.push_back(v("ret_irq",    CR,  8'h00, 1'b1, S ? 8'h34 : 8'hF8, F0));
    tbl.push_back(v("jump_40",    CJ,  8'h40, 1'b1, 8'h40, F0));
    tbl.push_back(v("call1",      CC,  8'hA0, 1'b1, 8'hA0, F0));
    tbl.push_back(v("call2",      CC,  8'hB0, 1'b1, 8'hB0, F0));
    tbl.push_back(v("call3",      CC,  8'hC0, 1'b1, 8'hC0, F0));
    tbl.push_back(v("call4",      CC,  8'hD0, 1'b1, 8'hD0, F0));
    tbl.push_back(v("call5_ovf",  CC,  8'hE0, 1'b1, 8'hE0, FO));
    tbl.push_back(v("ret1",       CR,  8'h00, 1'b1, S ? 8'hC4 : 8'hE4, FO));
    tbl.push_back(v("ret2",       CR,  8'h00, 1'b1, S ? 8'hB4 : 8'hE8, FO));
    tbl.push_back(v("ret3",       CR,  8'h00, 1'b1, S ? 8'hA4 : 8'hEC, FO));
    tbl.push_back(v("ret4",       CR,  8'h00, 1'b1, S ? 8'h44 : 8'hF0, FO));
    tbl.push_back(v("ret5_unf",   CR,  8'h00, 1'b1, S ? 8'h48 : 8'hF4, FOU));
    tbl.push_back(v("jump_call",  CJC, 8'h44, 1'b1, 8'h44, FOU));
    tbl.push_back(v("ret_empty",  CR,  8'h00, 1'b1, 8'h48, FOU));
    tbl.push_back(v("stall_ack",  CSA, 8'h00, 1'b0, 8'h4C, FOU));
    tbl.push_back(v("resume_4c",  C0,  8'h00, 1'b1, 8'h4C, FOU));
    tbl.push_back(v("jump_44",    CJ,  8'h44, 1'b1, 8'h44, FOU));
    tbl.push_back(v("hold_44",    C0,  8'h00, 1'b1, 8'h44, FOU));

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset in the middle of an outstanding fetch at 44.
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst", sample(), '{req: 1'b0, addr: 8'h00, flags: F0});
    @(posedge clk);
    #1;
    check("rst_hold", sample(), '{req: 1'b0, addr: 8'h00, flags: F0});
    reset_n = 1'b1;
    check("rel_boot", sample(), '{req: 1'b0, addr: 8'h00, flags: F0});
    run_vec(v("rel_first", C0, 8'h00, 1'b1, 8'h00, F0));
    run_vec(v("irq_again", CI, 8'h00, 1'b1, 8'hF0, FI));
    run_vec(v("iack_once", C0, 8'h00, 1'b1, 8'hF0, F0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
